// File: rtl/audio_pkg.sv
// Shared types for the I2S capture path: stereo frame packing and receiver FSM states.
package audio_pkg;

    localparam int unsigned SAMPLE_W_DEFAULT = 16;
    // Each channel occupies one half of the 32-bit frame word.
    localparam int unsigned CHAN_W = 16;

    typedef struct packed {
        logic [CHAN_W-1:0] left;
        logic [CHAN_W-1:0] right;
    } audio_frame_t;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StLeft,
        StRight
    } i2s_rx_state_e;

endpackage

// File: rtl/i2s_deserializer.sv
// I2S receiver: synchronises sclk/lrck/data into clk_sys, detects sclk rising edges and
// deserialises MSB-first left/right words into one-cycle push strobes with a packed frame.
module i2s_deserializer
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W = SAMPLE_W_DEFAULT
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         audio_sclk_in,
    input  logic         audio_lrck_in,
    input  logic         audio_adc,
    input  logic         capture_en,
    output logic         push,
    output audio_frame_t frame
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_W + 1);

    logic [2:0]          sclk_sync;
    logic [1:0]          lrck_sync;
    logic [1:0]          data_sync;
    logic                sclk_rise;
    logic                lrck_s;
    logic                data_s;
    logic                lrck_fall;
    logic                lrck_rise;
    logic                word_full;

    i2s_rx_state_e       state;
    logic [CNT_W-1:0]    bitcnt;
    logic                lrck_prev;
    logic                left_ok;
    logic [SAMPLE_W-1:0] left_sr;
    logic [SAMPLE_W-1:0] right_sr;

    // Two-flop synchronisers; the third sclk flop provides the edge reference.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sclk_sync <= '0;
            lrck_sync <= '0;
            data_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], audio_sclk_in};
            lrck_sync <= {lrck_sync[0], audio_lrck_in};
            data_sync <= {data_sync[0], audio_adc};
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign lrck_s    = lrck_sync[1];
    assign data_s    = data_sync[1];
    assign lrck_fall = lrck_prev & ~lrck_s;
    assign lrck_rise = ~lrck_prev & lrck_s;
    assign word_full = (bitcnt == CNT_W'(SAMPLE_W));

    // Receiver FSM; the bit sampled on an lrck change is the previous word's LSB and is skipped.
    always_ff @(posedge clk_sys) begin
        push <= 1'b0;
        if (reset) begin
            state     <= StIdle;
            bitcnt    <= '0;
            lrck_prev <= 1'b0;
            left_ok   <= 1'b0;
            left_sr   <= '0;
            right_sr  <= '0;
            frame     <= '0;
        end else begin
            if (sclk_rise) begin
                lrck_prev <= lrck_s;
            end
            if (!capture_en) begin
                state   <= StIdle;
                bitcnt  <= '0;
                left_ok <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: state <= StSync;
                    StSync: begin
                        if (sclk_rise && lrck_fall) begin
                            state  <= StLeft;
                            bitcnt <= '0;
                        end
                    end
                    StLeft: begin
                        if (sclk_rise) begin
                            if (lrck_rise) begin
                                state   <= StRight;
                                left_ok <= word_full;
                                bitcnt  <= '0;
                            end else if (!word_full) begin
                                left_sr <= {left_sr[SAMPLE_W-2:0], data_s};
                                bitcnt  <= bitcnt + CNT_W'(1);
                            end
                        end
                    end
                    StRight: begin
                        if (sclk_rise) begin
                            if (lrck_fall) begin
                                state  <= StLeft;
                                bitcnt <= '0;
                                // A short channel drops the frame but keeps word alignment.
                                if (left_ok && word_full) begin
                                    push        <= 1'b1;
                                    frame.left  <= CHAN_W'(left_sr);
                                    frame.right <= CHAN_W'(right_sr);
                                end
                            end else if (!word_full) begin
                                right_sr <= {right_sr[SAMPLE_W-2:0], data_s};
                                bitcnt   <= bitcnt + CNT_W'(1);
                            end
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: rtl/audio_capture.sv
// I2S capture top: deserialiser feeding a single-clock frame FIFO drained by the CPU bus.
// Optional feature macro: AUDIO_CAPTURE_DROP_COUNT_EN enables the saturating drop counter;
// without it drop_count is tied to zero.
module audio_capture
    import audio_pkg::*;
#(
    parameter int unsigned FIFO_AW  = 10,
    parameter int unsigned SAMPLE_W = SAMPLE_W_DEFAULT
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               audio_sclk_in,
    input  logic               audio_lrck_in,
    input  logic               audio_adc,
    input  logic               capture_en,
    input  logic               audio_flush,
    input  logic               audio_bus_rd,
    output logic [31:0]        audio_bus_out,
    output logic [FIFO_AW:0]   audio_buffer_fill,
    output logic               empty,
    output logic               overflow,
    output logic [15:0]        drop_count
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    logic         push;
    audio_frame_t frame;

    audio_frame_t     mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             drop;

    i2s_deserializer #(
        .SAMPLE_W (SAMPLE_W)
    ) u_deser (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .audio_sclk_in (audio_sclk_in),
        .audio_lrck_in (audio_lrck_in),
        .audio_adc     (audio_adc),
        .capture_en    (capture_en),
        .push          (push),
        .frame         (frame)
    );

    assign audio_buffer_fill = wr_ptr - rd_ptr;
    assign full              = audio_buffer_fill[FIFO_AW];
    assign empty             = (audio_buffer_fill == '0);

    // A pop frees the slot in the same cycle, so a push into a full FIFO then still lands.
    assign do_pop  = audio_bus_rd & ~empty & ~audio_flush;
    assign do_push = push & ~audio_flush & (~full | do_pop);
    assign drop    = push & ~audio_flush & full & ~do_pop;

    // Frame storage; no reset needed since pointers define validity.
    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= frame;
        end
    end

    // Read/write pointers with flush.
    always_ff @(posedge clk_sys) begin
        if (reset || audio_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Registered bus read data; holds when no pop occurs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            audio_bus_out <= '0;
        end else if (do_pop) begin
            audio_bus_out <= mem[rd_ptr[FIFO_AW-1:0]];
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk_sys) begin
        if (reset || audio_flush) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef AUDIO_CAPTURE_DROP_COUNT_EN
    logic [15:0] drop_cnt;

    // Saturating count of dropped frames.
    always_ff @(posedge clk_sys) begin
        if (reset || audio_flush) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign drop_count = drop_cnt;
`else
    assign drop_count = '0;
`endif

endmodule

// File: doc/audio_capture.md
# audio_capture

Single-clock I2S capture path: synchronises an external I2S ADC stream (bit clock, word select, data) into `clk_sys`, deserialises 16-bit left/right samples and buffers each stereo frame as one 32-bit word in an internal FIFO. The CPU bus drains the FIFO. It is the receive counterpart of the audio playback path. It presents the same `{left, right}` packing and fill-level reporting to software.

## Interface
- `FIFO_AW`, 10: FIFO address width; depth = 2^FIFO_AW frames.
- `SAMPLE_W`, 16: bits captured per channel; MSB-first, extra transmitted bits ignored.

Ports:
- `clk_sys  in  1`: system clock; the only clock.
- `reset  in  1`: synchronous, active-high.
- `audio_sclk_in  in  1`: I2S bit clock, asynchronous, ≤ clk_sys/4.
- `audio_lrck_in  in  1`: I2S word select, asynchronous; 0 = left, 1 = right.
- `audio_adc  in  1`: I2S serial data, asynchronous.
- `capture_en  in  1`: level; 0 stops capture and clears deserialiser state.
- `audio_flush  in  1`: pulse; empties the FIFO and clears `overflow`.
- `audio_bus_rd  in  1`: pop request, one frame per cycle asserted.
- `audio_bus_out  out  32`: `{left[15:0], right[15:0]}` of the last popped frame, signed.
- `audio_buffer_fill  out  FIFO_AW+1`: frames currently stored.
- `empty  out  1`: fill == 0.
- `overflow  out  1`: sticky; set when a completed frame was dropped because the FIFO was full.
- `drop_count  out  16`: dropped-frame counter (see Configuration).

## Operation
- **Input synchronisation:** each of sclk, lrck and data passes through 2 flops. A third flop on sclk gives rising-edge detect `sclk_rise`.
- **Sampling:** on each `sclk_rise`, sample lrck and data. `lrck_prev` holds the lrck value from the previous edge.
- **Deserialiser FSM** (`IDLE`, `SYNC`, `LEFT`, `RIGHT`):
  - `IDLE`: entered when `capture_en` = 0; moves to `SYNC` when `capture_en` = 1.
  - `SYNC`: waits for a 1→0 lrck transition, then goes to `LEFT` with `bitcnt` = 0. The partial frame is discarded.
  - `LEFT`/`RIGHT`: I2S one-bit delay applies. The data bit sampled on the edge where lrck changes belongs to the previous word and is ignored. On each later edge, if `bitcnt` < SAMPLE_W, shift the data bit into that channel's register and increment `bitcnt`.
  - 0→1 lrck change: `LEFT`→`RIGHT`, `bitcnt` = 0.
  - 1→0 lrck change: `RIGHT`→`LEFT`, and a frame is pushed if both channels reached SAMPLE_W bits.
  - A channel that ended short (`bitcnt` < SAMPLE_W) invalidates the frame: no push, and the FSM stays in sync.
- **Push:** a one-cycle `push` strobe with frame `{L, R}`. If the FIFO is full, drop the frame, set `overflow` and increment `drop_count`.
- **FIFO:** single-clock circular buffer.
  - Pointers wrap modulo 2^FIFO_AW. Fill is the difference of (FIFO_AW+1)-bit pointers.
  - `audio_bus_rd` while empty is ignored and `audio_bus_out` holds.
  - Simultaneous push and pop both take effect; fill is unchanged.
  - When full, a simultaneous pop and push is accepted (pop first), so no drop.
- **Flush:**
  - `audio_flush` zeroes both pointers and clears `overflow` and `drop_count`.
  - A push in the same cycle as a flush is discarded.
  - The deserialiser is unaffected by flush.
- **Disable:** `capture_en` = 0 returns the FSM to `IDLE` on the next cycle. A frame in progress is discarded; FIFO contents are kept.

## Timing
- Reset values: `audio_bus_out` = 0, `audio_buffer_fill` = 0, `empty` = 1, `overflow` = 0, `drop_count` = 0; FSM = `IDLE`.
- Pin-to-`sclk_rise` latency: 3 clk_sys cycles.
- `push` is asserted the cycle after the `sclk_rise` that sees lrck 1→0. `audio_buffer_fill` and `empty` update on the following cycle (registered).
- Pop: `audio_bus_rd` at cycle N gives `audio_bus_out` valid at N+1 and fill decremented at N+1.
- Reset mid-frame discards all state, including FIFO contents.

## Configuration
- `AUDIO_CAPTURE_DROP_COUNT_EN`:
  - Defined: `drop_count` is a 16-bit counter that saturates at 0xFFFF, increments once per dropped frame and clears on reset/flush.
  - Undefined: the counter logic is absent and `drop_count` is tied to 0. `overflow` behaves identically either way.

## Structure
- `audio_pkg`:
  - `SAMPLE_W` default.
  - `audio_frame_t` (packed struct `{left, right}`, 32 bits).
  - FSM state enum `i2s_rx_state_e`.
- Sub-module `i2s_deserializer`: synchronisers, edge detect, FSM, and outputs `push`/frame.
- FIFO, flush, overflow and counter logic live in `audio_capture`.

## Test plan
- Reset, then `capture_en` = 1, sclk = clk_sys/8, frames L = 0x1234, R = 0xABCD → after the first discarded partial frame, fill = 1 and one pop returns 0x1234ABCD.
- Transmit 24-bit words L = 0x80FF_EE, R = 0x7F00_11 → popped word 0x80FF7F00; trailing bits ignored.
- Fill the FIFO to 2^FIFO_AW with no reads, then send 3 more frames → fill stays at max, `overflow` = 1, `drop_count` = 3 (macro defined) or 0 (macro undefined).
- With the FIFO full, assert `audio_bus_rd` in the same cycle as a push → no drop, fill unchanged, oldest frame output.
- Right channel cut to 10 bits by an early lrck 1→0 → no push; the next full frame 0x00010002 is captured.
- Deassert `capture_en` mid-left-word, then `audio_flush`, then re-enable → fill = 0, `overflow` = 0, and the first complete frame after resync is captured correctly.
